// File: rtl/cpu64_hazard_ctrl_pkg.sv
// Shared types for the cpu64 pipeline hazard controller: state encoding,
// per-stage control bundle and small helpers used by the controller.
package cpu64_hazard_ctrl_pkg;

   localparam int HZ_STATE_W = 2;

   typedef enum logic [HZ_STATE_W-1:0] {
      HZ_RUN      = 2'd0,
      HZ_MDU_WAIT = 2'd1,
      HZ_DRAIN    = 2'd2
   } hz_state_e;

   typedef struct packed {
      logic if_stall;
      logic id_stall;
      logic id_bubble;
      logic exe_stall;
      logic exe_bubble;
      logic mem_stall;
      logic if_flush;
      logic id_flush;
   } hz_ctrl_t;

   localparam hz_ctrl_t HZ_CTRL_NONE = '0;

   // Control seen in free-running operation: only a load-use hazard holds ID.
   function automatic hz_ctrl_t hz_run_ctrl(input logic load_use);
      hz_ctrl_t c;
      c           = HZ_CTRL_NONE;
      c.if_stall  = load_use;
      c.id_stall  = load_use;
      c.id_bubble = load_use;
      return c;
   endfunction

   function automatic hz_state_e hz_legalize(input hz_state_e s);
      hz_state_e r;
      case (s)
         HZ_RUN, HZ_MDU_WAIT, HZ_DRAIN: r = s;
         default:                       r = HZ_RUN;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cpu64_hazard_ctrl_if.sv
// Hazard sources from the pipeline and stage controls back to it.
// slave = hazard controller, master = pipeline side.
interface cpu64_hazard_ctrl_if
   import cpu64_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) ();

   logic             rs1_load_use;
   logic             rs2_load_use;
   logic             mdu_start;
   logic             mdu_done;
   logic             serialize;
   logic             pipe_empty;
   logic             redirect;
   logic             dmem_stall;

   logic             if_stall;
   logic             id_stall;
   logic             id_bubble;
   logic             exe_stall;
   logic             exe_bubble;
   logic             mem_stall;
   logic             if_flush;
   logic             id_flush;
   logic [HZ_STATE_W-1:0] state;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output rs1_load_use, rs2_load_use, mdu_start, mdu_done,
             serialize, pipe_empty, redirect, dmem_stall,
      input  if_stall, id_stall, id_bubble, exe_stall, exe_bubble,
             mem_stall, if_flush, id_flush, state, stall_cycles
   );

   modport slave (
      input  rs1_load_use, rs2_load_use, mdu_start, mdu_done,
             serialize, pipe_empty, redirect, dmem_stall,
      output if_stall, id_stall, id_bubble, exe_stall, exe_bubble,
             mem_stall, if_flush, id_flush, state, stall_cycles
   );

endinterface

// File: rtl/cpu64_hazard_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module cpu64_hazard_ctrl_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_o <= '0;
      end else if (inc_i && (count_o != '1)) begin
         count_o <= count_o + W'(1);
      end
   end

endmodule

// File: rtl/cpu64_hazard_ctrl.sv
// Central stall/bubble/flush controller for the 5-stage cpu64 pipeline.
//
// state       | meaning
// HZ_RUN      | free running; load-use and serialise hazards evaluated
// HZ_MDU_WAIT | multi-cycle MUL/DIV busy in EXE, NOPs fed into MEM
// HZ_DRAIN    | FENCE/CSR held in ID until EXE/MEM/WB are empty
module cpu64_hazard_ctrl
   import cpu64_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   cpu64_hazard_ctrl_if.slave  bus
);

   hz_state_e state_q;
   hz_state_e state_d;
   hz_ctrl_t  ctrl;
   logic      load_use;

   assign load_use = bus.rs1_load_use | bus.rs2_load_use;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= HZ_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Mealy outputs so a hazard takes effect in the cycle it is flagged.
   always_comb begin
      ctrl    = HZ_CTRL_NONE;
      state_d = HZ_RUN;
      if (rst_ni) begin
         if (bus.dmem_stall) begin
            ctrl.if_stall  = 1'b1;
            ctrl.id_stall  = 1'b1;
            ctrl.exe_stall = 1'b1;
            ctrl.mem_stall = 1'b1;
            state_d        = hz_legalize(state_q);
         end else if (bus.redirect && (state_q != HZ_MDU_WAIT)) begin
            // The younger serialising op in ID is flushed, so DRAIN is abandoned.
            ctrl.if_flush = 1'b1;
            ctrl.id_flush = 1'b1;
            state_d       = HZ_RUN;
         end else begin
            case (state_q)
               HZ_MDU_WAIT: begin
                  if (!bus.mdu_done) begin
                     ctrl.if_stall   = 1'b1;
                     ctrl.id_stall   = 1'b1;
                     ctrl.exe_stall  = 1'b1;
                     ctrl.exe_bubble = 1'b1;
                     state_d         = HZ_MDU_WAIT;
                  end else begin
                     ctrl    = hz_run_ctrl(load_use);
                     state_d = HZ_RUN;
                  end
               end
               HZ_DRAIN: begin
                  if (!bus.pipe_empty) begin
                     ctrl.if_stall  = 1'b1;
                     ctrl.id_stall  = 1'b1;
                     ctrl.id_bubble = 1'b1;
                     state_d        = HZ_DRAIN;
                  end else begin
                     ctrl    = hz_run_ctrl(load_use);
                     state_d = HZ_RUN;
                  end
               end
               HZ_RUN: begin
                  ctrl = hz_run_ctrl(load_use);
                  if (bus.mdu_start && !bus.mdu_done) begin
                     state_d = HZ_MDU_WAIT;
                  end else if (bus.serialize && !bus.pipe_empty && !load_use) begin
                     state_d = HZ_DRAIN;
                  end else begin
                     state_d = HZ_RUN;
                  end
               end
               default: begin
                  ctrl    = hz_run_ctrl(load_use);
                  state_d = HZ_RUN;
               end
            endcase
         end
      end
   end

   assign bus.if_stall   = ctrl.if_stall;
   assign bus.id_stall   = ctrl.id_stall;
   assign bus.id_bubble  = ctrl.id_bubble;
   assign bus.exe_stall  = ctrl.exe_stall;
   assign bus.exe_bubble = ctrl.exe_bubble;
   assign bus.mem_stall  = ctrl.mem_stall;
   assign bus.if_flush   = ctrl.if_flush;
   assign bus.id_flush   = ctrl.id_flush;
   assign bus.state      = state_q;

   cpu64_hazard_ctrl_sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (ctrl.if_stall),
      .count_o (bus.stall_cycles)
   );

endmodule
